// File: rtl/dmem_line_responder.sv
// dmem_line_responder
//
// Main-memory responder for the data cache's line refill, writeback and drain
// traffic. It takes one 128-bit line request at a time, counts down a fixed
// access latency, performs the array access and holds the response until it
// is consumed.
//
// Optional feature macro: DMEM_ADDR_CHECK_EN. When defined, requests that are
// misaligned or beyond the array range complete with resp_error=1 and never
// touch the array. When undefined, the low and upper address bits are ignored.
//
// Parameters:
//   LINES      - number of 128-bit lines in mem_array
//   LINE_IDX_W - line index width, clog2(LINES)
//   LATENCY    - cycles from request acceptance to resp_valid (1..255)
//
// Ports:
//   clock       - clock, rising edge
//   reset       - synchronous active-high reset
//   req_valid   - request present
//   req_ready   - responder can accept a request
//   req_write   - 1 = line write, 0 = line read
//   req_addr    - byte address of the line
//   req_wdata   - write line, word0 in bits [31:0]
//   resp_valid  - response present
//   resp_ready  - requester accepts the response
//   resp_rdata  - read line, 0 for writes and errors
//   resp_error  - request was rejected by the address check
module dmem_line_responder #(
  parameter int unsigned LINES      = 1024,
  parameter int unsigned LINE_IDX_W = 10,
  parameter int unsigned LATENCY    = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [31:0]  req_addr,
  input  logic [127:0] req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [127:0] resp_rdata,
  output logic         resp_error
);

  localparam logic [7:0] LatencyM1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              count_q, count_d;
  logic                    write_q;
  logic                    error_q;
  logic [LINE_IDX_W-1:0]   index_q;
  logic [127:0]            wdata_q;
  logic [127:0]            rdata_q;
  logic                    resp_error_q;

  // Not reset: contents survive reset and are preloaded by benches.
  logic [127:0] mem_array [0:LINES-1];

  logic accept;
  logic access;
  logic req_error;

`ifdef DMEM_ADDR_CHECK_EN
  assign req_error = (req_addr[3:0] != 4'd0) || (req_addr[31:LINE_IDX_W+4] != '0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:LINE_IDX_W+4], req_addr[3:0]};
  assign req_error        = 1'b0;
`endif

  assign req_ready  = (state_q == StIdle) && !reset;
  assign accept     = req_valid && req_ready;
  // Single cycle on which the array is read or written (BUSY -> RESP edge).
  assign access     = (state_q == StBusy) && (count_q == 8'd0);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_error = resp_error_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StBusy;
          count_d = LatencyM1;
        end
      end
      StBusy: begin
        if (count_q == 8'd0) begin
          state_d = StResp;
        end else begin
          count_d = count_q - 8'd1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      count_q      <= 8'd0;
      write_q      <= 1'b0;
      error_q      <= 1'b0;
      index_q      <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (accept) begin
        write_q <= req_write;
        error_q <= req_error;
        index_q <= req_addr[LINE_IDX_W+3:4];
        wdata_q <= req_wdata;
      end
      if (access) begin
        rdata_q      <= (write_q || error_q) ? '0 : mem_array[index_q];
        resp_error_q <= error_q;
      end
    end
  end

  // Gated by reset so a reset on the commit edge discards the pending write.
  always_ff @(posedge clock) begin
    if (!reset && access && write_q && !error_q) begin
      mem_array[index_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_line_responder.sv
module tb_dmem_line_responder;

  logic         clock = 1'b0;
  logic         reset = 1'b1;

  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [31:0]  req_addr = 32'd0;
  logic [127:0] req_wdata = 128'd0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [127:0] resp_rdata;
  logic         resp_error;

  logic         q1_req_valid = 1'b0;
  logic         q1_req_ready;
  logic [31:0]  q1_req_addr = 32'd0;
  logic         q1_resp_valid;
  logic [127:0] q1_resp_rdata;
  logic         q1_resp_error;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] L0 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] W1 = 128'hDEADBEEF_CAFEF00D_12345678_00000005;
  localparam logic [127:0] P2 = 128'h22222222_22222222_22222222_22222222;
  localparam logic [127:0] Q2 = 128'h99999999_88888888_77777777_66666666;
  localparam logic [127:0] B1 = 128'h0000000B_0000000A_00000009_00000008;

  always #5 clock = ~clock;

  dmem_line_responder #(.LINES(1024), .LINE_IDX_W(10), .LATENCY(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error)
  );

  dmem_line_responder #(.LINES(1024), .LINE_IDX_W(10), .LATENCY(1)) dut1 (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (q1_req_valid),
    .req_ready  (q1_req_ready),
    .req_write  (1'b0),
    .req_addr   (q1_req_addr),
    .req_wdata  (128'd0),
    .resp_valid (q1_resp_valid),
    .resp_ready (1'b1),
    .resp_rdata (q1_resp_rdata),
    .resp_error (q1_resp_error)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one request on dut; lat = cycles from acceptance to resp_valid, -1 on timeout.
  task automatic run_req(input logic wr, input logic [31:0] addr, input logic [127:0] wd,
                         output int lat);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    lat = -1;
    for (int i = 0; i < 20 && !req_ready; i++) step();
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (req_ready !== 1'b0) begin failures++;
      $display("FAIL reset_req_ready_low got %b expected 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++;
      $display("FAIL reset_resp_valid got %b expected 0", resp_valid); end
    checks++; if (resp_rdata !== 128'd0) begin failures++;
      $display("FAIL reset_resp_rdata got %h expected 0", resp_rdata); end
    checks++; if (resp_error !== 1'b0) begin failures++;
      $display("FAIL reset_resp_error got %b expected 0", resp_error); end
    reset = 1'b0;
    step();
    checks++; if (req_ready !== 1'b1) begin failures++;
      $display("FAIL reset_req_ready_after got %b expected 1", req_ready); end
    checks++; if (q1_req_ready !== 1'b1) begin failures++;
      $display("FAIL reset_q1_req_ready_after got %b expected 1", q1_req_ready); end
  endtask

  task automatic test_read();
    int lat;
    run_req(1'b0, 32'h0, 128'd0, lat);
    checks++; if (lat !== 5) begin failures++;
      $display("FAIL read_latency got %0d expected 5", lat); end
    checks++; if (resp_rdata !== L0) begin failures++;
      $display("FAIL read_rdata got %h expected %h", resp_rdata, L0); end
    checks++; if (resp_error !== 1'b0) begin failures++;
      $display("FAIL read_error got %b expected 0", resp_error); end
    handshake();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++;
      $display("FAIL read_return_idle got valid=%b ready=%b expected valid=0 ready=1",
               resp_valid, req_ready); end
  endtask

  task automatic test_write();
    int lat;
    run_req(1'b1, 32'h10, W1, lat);
    checks++; if (lat !== 5) begin failures++;
      $display("FAIL write_latency got %0d expected 5", lat); end
    checks++; if (resp_rdata !== 128'd0) begin failures++;
      $display("FAIL write_rdata got %h expected 0", resp_rdata); end
    checks++; if (resp_error !== 1'b0) begin failures++;
      $display("FAIL write_error got %b expected 0", resp_error); end
    handshake();
    checks++; if (dut.mem_array[1][31:0] !== 32'd5) begin failures++;
      $display("FAIL write_array_word0 got %h expected 5", dut.mem_array[1][31:0]); end
    checks++; if (dut.mem_array[1] !== W1) begin failures++;
      $display("FAIL write_array_line got %h expected %h", dut.mem_array[1], W1); end
    run_req(1'b0, 32'h10, 128'd0, lat);
    checks++; if (resp_rdata !== W1) begin failures++;
      $display("FAIL write_readback got %h expected %h", resp_rdata, W1); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    run_req(1'b0, 32'h0, 128'd0, lat);
    checks++; if (lat !== 5) begin failures++;
      $display("FAIL bp_latency got %0d expected 5", lat); end
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h10;
    for (int i = 0; i < 4; i++) begin
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== L0 || resp_error !== 1'b0 ||
                    req_ready !== 1'b0) begin failures++;
        $display("FAIL bp_hold cycle %0d got valid=%b rdata=%h err=%b ready=%b expected 1 %h 0 0",
                 i, resp_valid, resp_rdata, resp_error, req_ready, L0); end
      step();
    end
    handshake();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++;
      $display("FAIL bp_bubble got valid=%b ready=%b expected valid=0 ready=1",
               resp_valid, req_ready); end
    step();
    checks++; if (req_ready !== 1'b0) begin failures++;
      $display("FAIL bp_second_accept got ready=%b expected 0", req_ready); end
    req_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
    checks++; if (lat !== 5) begin failures++;
      $display("FAIL bp_second_latency got %0d expected 5", lat); end
    checks++; if (resp_rdata !== W1) begin failures++;
      $display("FAIL bp_second_rdata got %h expected %h", resp_rdata, W1); end
    handshake();
  endtask

  task automatic test_addr_check();
    int lat;
`ifdef DMEM_ADDR_CHECK_EN
    run_req(1'b1, 32'h4, {128{1'b1}}, lat);
    checks++; if (lat !== 5 || resp_error !== 1'b1 || resp_rdata !== 128'd0) begin failures++;
      $display("FAIL chk_misaligned got lat=%0d err=%b rdata=%h expected 5 1 0",
               lat, resp_error, resp_rdata); end
    handshake();
    checks++; if (dut.mem_array[0] !== L0) begin failures++;
      $display("FAIL chk_misaligned_array got %h expected %h", dut.mem_array[0], L0); end
    run_req(1'b1, 32'h4000, {128{1'b1}}, lat);
    checks++; if (lat !== 5 || resp_error !== 1'b1 || resp_rdata !== 128'd0) begin failures++;
      $display("FAIL chk_range got lat=%0d err=%b rdata=%h expected 5 1 0",
               lat, resp_error, resp_rdata); end
    handshake();
    checks++; if (dut.mem_array[0] !== L0) begin failures++;
      $display("FAIL chk_range_array got %h expected %h", dut.mem_array[0], L0); end
`else
    logic [127:0] z;
    z = 128'h5A5A5A5A_A5A5A5A5_0F0F0F0F_F0F0F0F0;
    run_req(1'b1, 32'h4000, z, lat);
    checks++; if (lat !== 5 || resp_error !== 1'b0 || resp_rdata !== 128'd0) begin failures++;
      $display("FAIL wrap_resp got lat=%0d err=%b rdata=%h expected 5 0 0",
               lat, resp_error, resp_rdata); end
    handshake();
    checks++; if (dut.mem_array[0] !== z) begin failures++;
      $display("FAIL wrap_array got %h expected %h", dut.mem_array[0], z); end
    dut.mem_array[0] = L0;
`endif
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = Q2;
    step();
    req_valid = 1'b0;
    req_write = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin failures++;
      $display("FAIL rmid_during got valid=%b ready=%b expected 0 0", resp_valid, req_ready); end
    reset = 1'b0;
    step();
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++;
      $display("FAIL rmid_after got ready=%b valid=%b expected 1 0", req_ready, resp_valid); end
    repeat (8) step();
    checks++; if (resp_valid !== 1'b0) begin failures++;
      $display("FAIL rmid_no_resp got valid=%b expected 0", resp_valid); end
    checks++; if (dut.mem_array[2] !== P2) begin failures++;
      $display("FAIL rmid_array_line2 got %h expected %h", dut.mem_array[2], P2); end
    checks++; if (dut.mem_array[1] !== W1) begin failures++;
      $display("FAIL rmid_committed_line1 got %h expected %h", dut.mem_array[1], W1); end
  endtask

  task automatic test_back_to_back();
    int n;
    int t[2];
    logic [127:0] d[2];
    n = 0;
    t[0] = -1;
    t[1] = -1;
    d[0] = '0;
    d[1] = '0;
    q1_req_valid = 1'b1;
    q1_req_addr  = 32'h0;
    step();
    q1_req_addr  = 32'h10;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      step();
      if (q1_resp_valid && n < 2) begin
        t[n] = cyc;
        d[n] = q1_resp_rdata;
        n++;
        if (n == 2) q1_req_valid = 1'b0;
      end
    end
    q1_req_valid = 1'b0;
    checks++; if (t[0] !== 1) begin failures++;
      $display("FAIL b2b_first_time got %0d expected 1", t[0]); end
    checks++; if (t[1] - t[0] !== 3) begin failures++;
      $display("FAIL b2b_spacing got %0d expected 3", t[1] - t[0]); end
    checks++; if (d[0] !== L0) begin failures++;
      $display("FAIL b2b_first_rdata got %h expected %h", d[0], L0); end
    checks++; if (d[1] !== B1) begin failures++;
      $display("FAIL b2b_second_rdata got %h expected %h", d[1], B1); end
  endtask

  initial begin
    dut.mem_array[0]  = L0;
    dut.mem_array[2]  = P2;
    dut1.mem_array[0] = L0;
    dut1.mem_array[1] = B1;
    test_reset();
    test_read();
    test_write();
    test_backpressure();
    test_addr_check();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_line_responder.md
# dmem_line_responder

Main-memory responder for the data cache's line-refill and writeback traffic. It accepts one 128-bit line request at a time (read or write) over a valid/ready handshake and models main-memory access latency with a countdown. It returns a response over a second valid/ready handshake. It sits in the MEM stage behind the data cache and is the memory-side end of the cache's miss, writeback and drain (opcode 0x7f) requests.

## Interface

Parameters:
- `LINES`, default 1024: number of 128-bit lines in the storage array.
- `LINE_IDX_W`, default 10: line index width; must equal clog2(`LINES`).
- `LATENCY`, default 5: cycles from request acceptance to `resp_valid`; legal range 1..255.

Ports:
- `clock`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: responder can accept a request.
- `req_write`  in  1: 1 = line write, 0 = line read.
- `req_addr`  in  32: byte address of the line.
- `req_wdata`  in  128: write line; word0 is in bits [31:0].
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: requester accepts the response.
- `resp_rdata`  out  128: read line; 0 for writes and errors.
- `resp_error`  out  1: request was rejected (see Configuration).

## Operation

- Storage is the array `mem_array[0:LINES-1]`, 128 bits per line. Benches preload it hierarchically. Reset does not clear it.
- Line index is `req_addr[LINE_IDX_W+3:4]`.
- The FSM has three states:
  - IDLE: `req_ready`=1. On `req_valid & req_ready`, latch write, index, wdata and error; load the counter with `LATENCY-1`; go to BUSY.
  - BUSY: decrement the counter each cycle. When the counter is 0, perform the access, assert `resp_valid` and go to RESP.
  - RESP: hold `resp_valid`, `resp_rdata` and `resp_error` stable until `resp_valid & resp_ready`, then go to IDLE.
- Access is performed on the BUSY→RESP edge.
  - Read: `resp_rdata` is the array line.
  - Write: the array line takes the latched wdata; `resp_rdata` is 0.
  - Error: no array access; `resp_rdata` is 0 and `resp_error` is 1.
- Only one request is ever outstanding. Requests presented outside IDLE are not accepted and stay pending.
- Reset values: state=IDLE, `req_ready`=1 from the first cycle after reset deasserts (0 while reset is asserted), `resp_valid`=0, `resp_rdata`=0, `resp_error`=0, counter=0.
- Reset mid-operation: a request that has been accepted but whose write has not yet committed is discarded, and the array is unchanged. A write that has already committed stays in the array.

## Timing

- Request accepted at rising edge T. `resp_valid` is first high in the cycle after edge T+`LATENCY`. With `LATENCY`=1, the response appears in the cycle immediately after acceptance.
- A response handshake at edge R returns the FSM to IDLE. `req_ready` is high in the cycle after R, so there is a one-cycle bubble and a new request is accepted no earlier than edge R+1.
- Maximum throughput is one request per `LATENCY`+2 cycles.
- `resp_ready` high on the first `resp_valid` cycle consumes the response in that cycle.
- `resp_ready` is ignored while `resp_valid`=0.
- No combinational path from `req_*` to `resp_*`.
- `req_ready` depends only on state and `reset`.

## Configuration

`DMEM_ADDR_CHECK_EN` enables address checking.

- Defined: a request is an error if either of the following holds:
  - `req_addr[3:0]` ≠ 0 (misaligned line);
  - `req_addr[31:LINE_IDX_W+4]` ≠ 0 (out of range).
  
  An error request completes with the normal latency, sets `resp_error`=1, and never modifies the array.
- Undefined: the low 4 and upper address bits are ignored, the index wraps modulo `LINES`, and `resp_error` is tied to 0.

## Test plan

- Preload `mem_array[0]` = 128'h4_3_2_1 (words 1..4). Read `req_addr`=0x0 with `LATENCY`=5 → `resp_valid` high 5 cycles after acceptance, `resp_rdata` = that line, `resp_error`=0.
- Write `req_addr`=0x10 with `req_wdata[31:0]`=5, then read 0x10 → write response has `resp_rdata`=0; read returns word0=5; `mem_array[1][31:0]`=5.
- Hold `resp_ready`=0 for 4 cycles on a read response while driving a second `req_valid` → `resp_*` stays stable; `req_ready`=0 throughout; the second request is accepted exactly one cycle after the response handshake.
- With `DMEM_ADDR_CHECK_EN`, write to 0x4 and to 0x4000 → both give `resp_error`=1 and `resp_rdata`=0, and lines 0 and 0x400-wrapped are unchanged. Without the macro, a write to 0x4000 lands in line 0.
- Assert `reset` 2 cycles after accepting a write to 0x20 → `resp_valid`=0, `req_ready`=1 the cycle after reset deasserts, `mem_array[2]` unchanged.
- With `LATENCY`=1, issue back-to-back reads of 0x0 and 0x10 with `resp_ready`=1 → responses are 3 cycles apart, with correct data each.
